tge_tx_sched: RTL and testbench
===============================

Name: tge_tx_sched

Overview:
- Round-robin scheduler that shares one 10GbE TX lane between N_CH spectrometer channel FIFOs.
- Each FIFO holds IN_W-bit parallel words. The block grants one channel per packet, reads PKT_VALS words from that channel, and serializes each word into RATIO = IN_W/OUT_W beats.
- It prefixes every packet with a header beat and drives tx_data/tx_valid/tx_eof into the 10GbE core.
- Sits between the channel FIFOs and the 10GbE yellow-block TX interface.

Parameters:
- N_CH, 4, number of requesting channel FIFOs (2..16).
- IN_W, 256, FIFO word width; must be an integer multiple of OUT_W.
- OUT_W, 64, TX beat width.
- PKT_VALS, 32, FIFO words per packet (1..2^24-1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_pkt_rdy  in  N_CH  per-channel flag: FIFO holds at least PKT_VALS words.
- ch_empty  in  N_CH  per-channel FIFO empty.
- ch_re  out  N_CH  per-channel FIFO read enable, one-hot or zero.
- ch_dout  in  N_CH*IN_W  concatenated FIFO outputs; channel c occupies [(c+1)*IN_W-1 : c*IN_W]. Read latency is 1 cycle and dout is held until the next re.
- tx_afull  in  1  10GbE TX buffer almost full.
- tx_data  out  OUT_W  TX beat.
- tx_valid  out  1  beat valid.
- tx_eof  out  1  last beat of packet.
- tx_ch  out  8  channel id of the current or last packet.
- underflow  out  1  sticky; set when a read is needed while ch_empty[grant]=1; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): state IDLE; rr pointer 0; seq 0; all outputs 0.
- tx_data, tx_valid, tx_eof and tx_ch are registered, so each lags its state cycle by 1.
- IDLE:
  - If tx_afull=0 and |ch_pkt_rdy, pick the first requester at or after the rr pointer (wrapping), latch it as grant, go to HDR.
  - Otherwise stay in IDLE.
  - tx_afull is sampled only here; it is ignored mid-packet.
- HDR (1 cycle):
  - Emit header: [63:56]=grant id, [55:32]=PKT_VALS, [31:0]=seq. When OUT_W>64, upper bits are 0.
  - Assert ch_re[grant] if ch_empty[grant]=0, then go to SER with beat=0 and val=0.
  - If the FIFO is empty, go to STALL and set underflow.
- SER:
  - Emit ch_dout slice for grant, beat k = bits [(k+1)*OUT_W-1 : k*OUT_W] (LSB slice first); beat increments every cycle.
  - At beat=RATIO-1 with val<PKT_VALS-1: assert ch_re[grant] (if not empty), set beat←0, val←val+1; the stream is gapless.
  - If the FIFO is empty at that point: go to STALL, set underflow, no re.
  - At beat=RATIO-1 with val=PKT_VALS-1: assert tx_eof on this beat, seq←seq+1 (wraps at 2^32), rr pointer←(grant+1) mod N_CH, go to IDLE.
- STALL:
  - tx_valid=0.
  - When ch_empty[grant]=0, assert ch_re and return to SER at beat 0 of the pending val.
- Packet length on the wire is 1 + PKT_VALS*RATIO beats. There is a minimum 1 idle cycle between packets.
- Simultaneous requests: round-robin order only; a channel just served has lowest priority next time.
- ch_pkt_rdy deasserting after grant does not abort the packet.
- Reset mid-packet: outputs drop to 0 immediately, and no tx_eof is emitted for the truncated frame.
- ch_re is never asserted in IDLE or during reset.

Decomposition:
- Package tge_sched_pkg holds:
  - state encoding IDLE/HDR/SER/STALL;
  - header field offsets (CH_LSB=56, LEN_LSB=32, SEQ_LSB=0);
  - the function computing RATIO and its counter width $clog2(RATIO).
- Sub-module rr_arbiter (N_CH): inputs are the request vector and pointer; outputs are a one-hot grant, an index and a valid flag. It is purely combinational and called from the FSM; the pointer register lives in tge_tx_sched.

Test Plan:
1. Single channel: N_CH=4, PKT_VALS=2, ch_pkt_rdy=4'b0010, FIFO words W0,W1 -> 9 valid beats, contiguous. Beat0 = header 0x01_000002_00000000; then W0[63:0], W0[127:64], W0[191:128], W0[255:192], W1 slices; tx_eof only on beat 9; ch_re[1] pulses exactly twice.
2. All four channels ready continuously -> grants in order 0,1,2,3,0; header seq 0,1,2,3,4; ≥1 idle cycle between packets.
3. tx_afull=1 while ch_pkt_rdy≠0 -> no HDR and no ch_re. Deassert tx_afull -> HDR on the next cycle. Raise afull mid-packet -> packet completes unaffected.
4. ch_empty[grant] rises before the 2nd read -> tx_valid=0 while empty and underflow=1 (sticky). Refill -> resumes at W1 slice 0 with no duplicated or dropped slices; tx_eof still on the final beat.
5. Assert rst_n=0 during SER beat 2 -> tx_valid, tx_eof and ch_re go 0 immediately. After release: seq=0, grant restarts from channel 0.
6. Request pattern 4'b1001 with pointer at 1 -> channel 3 is granted first, then 0, then 3.

Source files
------------

// File: rtl/tge_tx_sched_pkg.sv
// Shared types, header layout and width helpers for the 10GbE TX scheduler.
package tge_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_SER   = 2'd2,
    ST_STALL = 2'd3
  } sched_state_e;

  // Header beat layout: channel id, packet length in FIFO words, sequence number
  localparam int CH_LSB  = 56;
  localparam int LEN_LSB = 32;
  localparam int SEQ_LSB = 0;
  localparam int CH_W    = 8;
  localparam int LEN_W   = 24;
  localparam int SEQ_W   = 32;

  // Number of TX beats needed to serialize one FIFO word
  function automatic int calc_ratio(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Beat counter width; a single-beat ratio still needs a 1-bit counter
  function automatic int beat_cnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/tge_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_CH-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down so the closest requester to ptr wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (IDX_W + 1)'(i);
      if (sum >= (IDX_W + 1)'(N_CH)) begin
        sum = sum - (IDX_W + 1)'(N_CH);
      end
      cand = sum[IDX_W-1:0];
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tge_tx_sched.sv
// Round-robin packet scheduler sharing one 10GbE TX lane between channel FIFOs.
module tge_tx_sched
  import tge_sched_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int IN_W     = 256,
  parameter int OUT_W    = 64,
  parameter int PKT_VALS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_CH-1:0]      ch_pkt_rdy,
  input  logic [N_CH-1:0]      ch_empty,
  output logic [N_CH-1:0]      ch_re,
  input  logic [N_CH*IN_W-1:0] ch_dout,
  input  logic                 tx_afull,
  output logic [OUT_W-1:0]     tx_data,
  output logic                 tx_valid,
  output logic                 tx_eof,
  output logic [7:0]           tx_ch,
  output logic                 underflow
);

  localparam int RATIO  = calc_ratio(IN_W, OUT_W);
  localparam int BEAT_W = beat_cnt_w(RATIO);
  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int VAL_W  = LEN_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);
  localparam logic [VAL_W-1:0]  LAST_VAL  = VAL_W'(PKT_VALS - 1);

  sched_state_e      state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [N_CH-1:0]   grant_oh_q, grant_oh_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [VAL_W-1:0]  val_q, val_d;
  logic              underflow_q, underflow_d;
  logic [OUT_W-1:0]  tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_eof_q, tx_eof_d;
  logic [7:0]        tx_ch_q, tx_ch_d;

  logic [N_CH-1:0]   arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;
  logic [IN_W-1:0]   cur_word;
  logic [OUT_W-1:0]  cur_beat;
  logic [OUT_W-1:0]  hdr_word;
  logic              grant_empty;
  logic              re_en;

  rr_arbiter #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (ch_pkt_rdy),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign grant_empty = ch_empty[grant_q];
  assign ch_re       = grant_oh_q & {N_CH{re_en}};

  // Pick the granted channel's FIFO word, then the slice for the current beat
  always_comb begin
    cur_word = '0;
    cur_beat = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant_q == IDX_W'(c)) begin
        cur_word = ch_dout[c*IN_W +: IN_W];
      end
    end
    for (int k = 0; k < RATIO; k++) begin
      if (beat_q == BEAT_W'(k)) begin
        cur_beat = cur_word[k*OUT_W +: OUT_W];
      end
    end
  end

  // Header beat: channel id, packet length, sequence number; upper bits zero
  always_comb begin
    hdr_word                     = '0;
    hdr_word[CH_LSB  +: CH_W]    = CH_W'(grant_q);
    hdr_word[LEN_LSB +: LEN_W]   = LEN_W'(PKT_VALS);
    hdr_word[SEQ_LSB +: SEQ_W]   = seq_q;
  end

  // Packet FSM: grant, header, serialize words, stall on empty FIFO
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_oh_d  = grant_oh_q;
    rr_ptr_d    = rr_ptr_q;
    seq_d       = seq_q;
    beat_d      = beat_q;
    val_d       = val_q;
    underflow_d = underflow_q;
    tx_data_d   = '0;
    tx_valid_d  = 1'b0;
    tx_eof_d    = 1'b0;
    tx_ch_d     = tx_ch_q;
    re_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!tx_afull && arb_valid) begin
          grant_d    = arb_idx;
          grant_oh_d = arb_gnt;
          state_d    = ST_HDR;
        end
      end

      ST_HDR: begin
        tx_data_d  = hdr_word;
        tx_valid_d = 1'b1;
        tx_ch_d    = 8'(grant_q);
        beat_d     = '0;
        val_d      = '0;
        if (!grant_empty) begin
          re_en   = 1'b1;
          state_d = ST_SER;
        end else begin
          underflow_d = 1'b1;
          state_d     = ST_STALL;
        end
      end

      ST_SER: begin
        tx_data_d  = cur_beat;
        tx_valid_d = 1'b1;
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          if (val_q == LAST_VAL) begin
            tx_eof_d = 1'b1;
            seq_d    = seq_q + 1'b1;
            rr_ptr_d = (grant_q == IDX_W'(N_CH - 1)) ? '0 : grant_q + 1'b1;
            state_d  = ST_IDLE;
          end else begin
            val_d = val_q + 1'b1;
            if (!grant_empty) begin
              re_en = 1'b1;
            end else begin
              underflow_d = 1'b1;
              state_d     = ST_STALL;
            end
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end

      ST_STALL: begin
        beat_d = '0;
        if (!grant_empty) begin
          re_en   = 1'b1;
          state_d = ST_SER;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered TX outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= '0;
      seq_q       <= '0;
      beat_q      <= '0;
      val_q       <= '0;
      underflow_q <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_eof_q    <= 1'b0;
      tx_ch_q     <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_oh_q  <= grant_oh_d;
      rr_ptr_q    <= rr_ptr_d;
      seq_q       <= seq_d;
      beat_q      <= beat_d;
      val_q       <= val_d;
      underflow_q <= underflow_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      tx_eof_q    <= tx_eof_d;
      tx_ch_q     <= tx_ch_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_eof    = tx_eof_q;
  assign tx_ch     = tx_ch_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_tge_tx_sched.sv
// Scoreboard bench for tge_tx_sched with behavioural channel FIFOs.
module tb_tge_tx_sched;

  localparam int N_CH     = 4;
  localparam int IN_W     = 256;
  localparam int OUT_W    = 64;
  localparam int PKT_VALS = 2;
  localparam int RATIO    = IN_W / OUT_W;
  localparam int DEPTH    = 16;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             eof;
    logic [7:0]       ch;
  } beat_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N_CH-1:0]      ch_pkt_rdy = '0;
  logic [N_CH-1:0]      ch_empty;
  logic [N_CH-1:0]      ch_re;
  logic [N_CH*IN_W-1:0] ch_dout;
  logic                 tx_afull = 1'b0;
  logic [OUT_W-1:0]     tx_data;
  logic                 tx_valid;
  logic                 tx_eof;
  logic [7:0]           tx_ch;
  logic                 underflow;

  logic [IN_W-1:0] fifo_mem [N_CH][DEPTH];
  logic [IN_W-1:0] dout_q   [N_CH];
  int              wr_ptr   [N_CH];
  int              rd_ptr   [N_CH];
  int              load_cnt [N_CH];
  int              exp_cnt  [N_CH];
  int              re_cnt   [N_CH];

  beat_t           exp_q[$];
  logic [31:0]     exp_seq;
  int              compared = 0;
  int              mismatched = 0;
  int              cycle = 0;
  int              beats_seen = 0;
  int              eof_seen = 0;
  int              hdr_cycle = 0;
  int              last_span = 0;
  bit              in_pkt = 0;
  bit              prev_eof = 0;

  always #5 clk = ~clk;

  tge_tx_sched #(
    .N_CH     (N_CH),
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .PKT_VALS (PKT_VALS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_pkt_rdy (ch_pkt_rdy),
    .ch_empty   (ch_empty),
    .ch_re      (ch_re),
    .ch_dout    (ch_dout),
    .tx_afull   (tx_afull),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_eof     (tx_eof),
    .tx_ch      (tx_ch),
    .underflow  (underflow)
  );

  // FIFO model: one-cycle read latency, output held between reads
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        rd_ptr[c] <= 0;
        dout_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (ch_re[c] && rd_ptr[c] < wr_ptr[c]) begin
          dout_q[c] <= fifo_mem[c][rd_ptr[c]];
          rd_ptr[c] <= rd_ptr[c] + 1;
        end
      end
    end
  end

  always_comb begin
    ch_empty = '0;
    ch_dout  = '0;
    for (int c = 0; c < N_CH; c++) begin
      ch_empty[c]               = (wr_ptr[c] == rd_ptr[c]);
      ch_dout[c*IN_W +: IN_W]   = dout_q[c];
    end
  end

  function automatic logic [IN_W-1:0] make_word(input int ch, input int n);
    logic [IN_W-1:0] w;
    w = '0;
    for (int k = 0; k < RATIO; k++) begin
      w[k*OUT_W +: OUT_W] = {8'(ch), 8'(n), 8'(k), 8'hA5, 32'h1234_5678 + 32'(ch*64 + n*8 + k)};
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic loadWord(input int ch);
    if (wr_ptr[ch] < DEPTH) begin
      fifo_mem[ch][wr_ptr[ch]] = make_word(ch, load_cnt[ch]);
      wr_ptr[ch]++;
      load_cnt[ch]++;
    end
  endtask

  // Load FIFO words for one packet of channel ch and queue its expected beats
  task automatic applyStimulus(input int ch, input int load_words);
    beat_t           e;
    logic [IN_W-1:0] w;
    for (int v = 0; v < load_words; v++) loadWord(ch);
    e.data          = '0;
    e.data[63:56]   = 8'(ch);
    e.data[55:32]   = 24'(PKT_VALS);
    e.data[31:0]    = exp_seq;
    e.eof           = 1'b0;
    e.ch            = 8'(ch);
    exp_q.push_back(e);
    for (int v = 0; v < PKT_VALS; v++) begin
      w = make_word(ch, exp_cnt[ch]);
      exp_cnt[ch]++;
      for (int k = 0; k < RATIO; k++) begin
        e.data = w[k*OUT_W +: OUT_W];
        e.eof  = (v == PKT_VALS - 1) && (k == RATIO - 1);
        e.ch   = 8'(ch);
        exp_q.push_back(e);
      end
    end
    exp_seq++;
  endtask

  task automatic applyReset();
    rst_n      = 1'b0;
    ch_pkt_rdy = '0;
    tx_afull   = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      wr_ptr[c]   = 0;
      load_cnt[c] = 0;
      exp_cnt[c]  = 0;
    end
    exp_q.delete();
    exp_seq = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_data", tx_data, 64'd0);
    checkOutput("reset_ctrl", {49'd0, tx_valid, tx_eof, underflow, ch_re, tx_ch}, 64'd0);
    #1 rst_n = 1'b1;
  endtask

  // Wait for the eof counter to reach target, then drop all requests
  task automatic runUntilEofs(input int target);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (eof_seen >= target) break;
    end
    ch_pkt_rdy = '0;
    checkOutput("eof_count", 64'(eof_seen), 64'(target));
  endtask

  // Monitor: pop the scoreboard on every valid beat and check framing rules
  initial begin
    beat_t e;
    for (int c = 0; c < N_CH; c++) re_cnt[c] = 0;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst_n) begin
        in_pkt   = 0;
        prev_eof = 0;
      end else begin
        checkOutput("re_onehot", 64'($onehot0(ch_re)), 64'd1);
        for (int c = 0; c < N_CH; c++) if (ch_re[c]) re_cnt[c]++;
        if (prev_eof) checkOutput("idle_gap", 64'(tx_valid), 64'd0);
        if (tx_valid) begin
          if (!in_pkt) begin
            hdr_cycle = cycle;
            in_pkt    = 1;
          end
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            checkOutput("tx_data", tx_data, e.data);
            checkOutput("tx_eof", 64'(tx_eof), 64'(e.eof));
            checkOutput("tx_ch", 64'(tx_ch), 64'(e.ch));
          end
          beats_seen++;
          if (tx_eof) begin
            eof_seen++;
            last_span = cycle - hdr_cycle + 1;
            in_pkt    = 0;
          end
        end
        prev_eof = tx_valid && tx_eof;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int re_base;
    int base;
    bit bad;

    // Single channel packet, header seq 0
    applyReset();
    re_base = re_cnt[1];
    applyStimulus(1, 2);
    ch_pkt_rdy = 4'b0010;
    runUntilEofs(1);
    checkOutput("t1_span", 64'(last_span), 64'(1 + PKT_VALS*RATIO));
    checkOutput("t1_re_pulses", 64'(re_cnt[1] - re_base), 64'd2);

    // All channels ready: 0,1,2,3,0 with seq 0..4
    applyReset();
    applyStimulus(0, 2);
    applyStimulus(1, 2);
    applyStimulus(2, 2);
    applyStimulus(3, 2);
    applyStimulus(0, 2);
    ch_pkt_rdy = 4'b1111;
    runUntilEofs(eof_seen + 5);

    // Requests 1001 with pointer at 1: 3, 0, 3
    applyStimulus(3, 2);
    applyStimulus(0, 2);
    applyStimulus(3, 2);
    ch_pkt_rdy = 4'b1001;
    runUntilEofs(eof_seen + 3);

    // Almost-full holds off the grant; mid-packet afull is ignored
    tx_afull = 1'b1;
    applyStimulus(1, 2);
    ch_pkt_rdy = 4'b0010;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      bad |= (ch_re != '0) | tx_valid;
    end
    checkOutput("afull_hold", 64'(bad), 64'd0);
    tx_afull = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("afull_release_re", 64'(ch_re), 64'b0010);
    repeat (3) @(negedge clk);
    tx_afull = 1'b1;
    runUntilEofs(eof_seen + 1);
    tx_afull = 1'b0;

    // FIFO runs dry before the second word: stall, sticky underflow, resume
    checkOutput("underflow_pre", 64'(underflow), 64'd0);
    applyStimulus(2, 1);
    ch_pkt_rdy = 4'b0100;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (underflow) break;
    end
    checkOutput("underflow_set", 64'(underflow), 64'd1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      bad |= tx_valid;
    end
    checkOutput("stall_valid", 64'(bad), 64'd0);
    loadWord(2);
    runUntilEofs(eof_seen + 1);
    checkOutput("underflow_sticky", 64'(underflow), 64'd1);

    // Reset in the middle of a packet, then restart from channel 0 with seq 0
    base = beats_seen;
    applyStimulus(3, 2);
    ch_pkt_rdy = 4'b1000;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (beats_seen >= base + 3) break;
    end
    checkOutput("midrst_pre_valid", 64'(tx_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ctrl", 64'({tx_valid, tx_eof, ch_re}), 64'd0);
    applyReset();
    checkOutput("post_reset_underflow", 64'(underflow), 64'd0);
    applyStimulus(0, 2);
    ch_pkt_rdy = 4'b1111;
    runUntilEofs(eof_seen + 1);

    repeat (4) @(negedge clk);
    checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
